// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and key-map tables for the 4x4 keypad responder.
// Column index 3 is the leftmost column (keys 1,4,7,0). Row index 3 is the top row.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Active-low column strobe patterns, one per column.
  localparam logic [3:0] COL_PAT_3 = 4'b0111;
  localparam logic [3:0] COL_PAT_2 = 4'b1011;
  localparam logic [3:0] COL_PAT_1 = 4'b1101;
  localparam logic [3:0] COL_PAT_0 = 4'b1110;

  // One-hot (active-high) column of each key code 0..F.
  localparam logic [3:0] KEY_COL [16] = '{
    4'b1000, 4'b1000, 4'b0100, 4'b0010,   // 0 1 2 3
    4'b1000, 4'b0100, 4'b0010, 4'b1000,   // 4 5 6 7
    4'b0100, 4'b0010, 4'b0001, 4'b0001,   // 8 9 A B
    4'b0001, 4'b0001, 4'b0010, 4'b0100    // C D E F
  };

  // One-hot (active-high) row of each key code 0..F.
  localparam logic [3:0] KEY_ROW [16] = '{
    4'b0001, 4'b1000, 4'b1000, 4'b1000,   // 0 1 2 3
    4'b0100, 4'b0100, 4'b0100, 4'b0010,   // 4 5 6 7
    4'b0010, 4'b0010, 4'b1000, 4'b0100,   // 8 9 A B
    4'b0010, 4'b0001, 4'b0001, 4'b0001    // C D E F
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Strobe pattern that selects the column holding the given key.
  function automatic logic [3:0] col_pattern(input logic [3:0] key);
    logic [3:0] onehot;
    onehot = KEY_COL[key];
    case (onehot)
      4'b1000: return COL_PAT_3;
      4'b0100: return COL_PAT_2;
      4'b0010: return COL_PAT_1;
      default: return COL_PAT_0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_visit_counter.sv
// keypad_visit_counter: detects the end of a target-column selection window
// (registered sel going 1->0) and counts such visits with saturation.
// o_hit flags the visit that brings the count up to i_limit.
module keypad_visit_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_visit,
  output logic             o_hit
);

  logic             r_sel;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   w_count_inc;

  assign o_visit     = r_sel & ~i_sel;
  assign w_count_inc = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
  assign o_hit       = o_visit && (w_count_inc >= {1'b0, i_limit});

  // Edge-detect register and saturating visit count; clear also drops the
  // stale selection so a new key never inherits a window edge from the old one.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sel   <= 1'b0;
      r_count <= '0;
    end else begin
      r_sel <= i_sel;
      if (o_visit && (r_count != {WIDTH{1'b1}})) begin
        r_count <= w_count_inc[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/keypad_responder.sv
// keypad_responder: row-driving end of a column-scanned 4x4 keypad.
// Accepts a key over valid/ready, presses it for HOLD_SCANS target-column
// visits, releases it for RELEASE_SCANS visits, then pulses done.
// Optional watchdog: define KEYPAD_RESP_TIMEOUT_EN to abort with done+error
// after TIMEOUT_CYCLES cycles without a target-column visit.
module keypad_responder
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS    = 4,
  parameter int RELEASE_SCANS = 2
`ifdef KEYPAD_RESP_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CNT_W = $clog2(max_int(HOLD_SCANS, RELEASE_SCANS) + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_SCANS);
  localparam logic [CNT_W-1:0] REL_LIM  = CNT_W'(RELEASE_SCANS);

  state_t           r_state;
  logic [3:0]       r_key;
  logic [3:0]       r_row;
  logic             r_done;

  logic             w_tgt_sel;
  logic             w_transfer;
  logic             w_visit;
  logic             w_hit;
  logic             w_timeout;
  logic             w_clear;
  logic [CNT_W-1:0] w_limit;

  assign w_tgt_sel  = (r_state != IDLE) && (col == col_pattern(r_key));
  assign w_transfer = (r_state == IDLE) && key_valid;
  assign w_limit    = (r_state == RELEASE) ? REL_LIM : HOLD_LIM;
  assign w_clear    = w_transfer | w_hit | w_timeout;

  keypad_visit_counter #(
    .WIDTH (CNT_W)
  ) u_visit_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_sel   (w_tgt_sel),
    .i_limit (w_limit),
    .o_visit (w_visit),
    .o_hit   (w_hit)
  );

`ifdef KEYPAD_RESP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_error;

  assign w_timeout = (r_state != IDLE) && !w_visit && (r_wd == WD_LAST);
  assign error     = r_error;

  // Watchdog: counts busy cycles since the last visit, restarts on each visit.
  always_ff @(posedge clk) begin
    if (rst || w_transfer || w_visit) begin
      r_wd <= '0;
    end else if ((r_state != IDLE) && (r_wd != WD_LAST)) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  // Error pulse accompanies done on a watchdog abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else begin
      r_error <= w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  // Main sequencer: latch key, press for the hold visits, release, signal done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= 4'h0;
      r_row   <= 4'hF;
      r_done  <= 1'b0;
    end else begin
      r_row  <= 4'hF;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (key_valid) begin
            r_key   <= key_code;
            r_state <= PRESS;
          end
        end
        PRESS: begin
          if (w_timeout) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (w_hit) begin
            r_state <= RELEASE;
          end else if (w_tgt_sel) begin
            r_row <= ~KEY_ROW[r_key];
          end
        end
        RELEASE: begin
          if (w_timeout || w_hit) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign row       = r_row;
  assign done      = r_done;
  assign key_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_keypad_responder.sv
// tb_keypad_responder: directed stimulus for keypad_responder, with a
// key-grid based reference model compared every cycle plus literal checks.
module tb_keypad_responder;

  localparam int HOLD = 4;
  localparam int REL  = 2;
  localparam int TO   = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col = 4'hF;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] row;
  logic       key_ready, busy, done, error;

  int vectors = 0;
  int miscompares = 0;
  logic check_en = 1'b0;

  keypad_responder #(
    .HOLD_SCANS    (HOLD),
    .RELEASE_SCANS (REL)
`ifdef KEYPAD_RESP_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Physical keypad layout: grid[c][r], c=0 is the col[3] column, r=0 is row[3].
  logic [3:0] grid [4][4] = '{
    '{4'h1, 4'h4, 4'h7, 4'h0},
    '{4'h2, 4'h5, 4'h8, 4'hF},
    '{4'h3, 4'h6, 4'h9, 4'hE},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };

  function automatic void locate(input logic [3:0] k, output int c, output int r);
    c = 0;
    r = 0;
    for (int ci = 0; ci < 4; ci++)
      for (int ri = 0; ri < 4; ri++)
        if (grid[ci][ri] == k) begin
          c = ci;
          r = ri;
        end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_st = 0;     // 0 idle, 1 pressing, 2 releasing
  logic [3:0] m_key = 4'h0;
  logic [3:0] m_row = 4'hF;
  logic       m_done = 1'b0;
  logic       m_err = 1'b0;
  logic       m_prev = 1'b0;
  int         m_vis = 0;
  int         m_wd = 0;

  always @(posedge clk) begin
    int c, r, nxt;
    logic sel, visit;
    logic [3:0] top;
    top = 4'b1000;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_st = 0; m_row = 4'hF; m_prev = 1'b0; m_vis = 0; m_wd = 0;
    end else begin
      locate(m_key, c, r);
      sel   = (m_st != 0) && (col == ~(top >> c));
      visit = m_prev && !sel;
      nxt   = m_st;
      if (m_st == 0) begin
        if (key_valid) begin
          m_key = key_code; nxt = 1; m_vis = 0; m_wd = 0;
          locate(m_key, c, r);
        end
      end else begin
        if (visit) begin
          m_vis++;
          m_wd = 0;
        end else begin
          m_wd++;
        end
`ifdef KEYPAD_RESP_TIMEOUT_EN
        if (!visit && m_wd >= TO) begin
          nxt = 0; m_done = 1'b1; m_err = 1'b1;
        end else
`endif
        if (m_st == 1 && m_vis == HOLD) begin
          nxt = 2; m_vis = 0;
        end else if (m_st == 2 && m_vis == REL) begin
          nxt = 0; m_done = 1'b1;
        end
      end
      m_row  = (m_st == 1 && nxt == 1 && sel) ? ~(top >> r) : 4'hF;
      m_prev = (nxt == m_st) ? sel : 1'b0;
      m_st   = nxt;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("row", {28'd0, row}, {28'd0, m_row});
      check("key_ready", {31'd0, key_ready}, {31'd0, m_st == 0});
      check("busy", {31'd0, busy}, {31'd0, m_st != 0});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("error", {31'd0, error}, {31'd0, m_err});
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] pats [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic scan_on = 1'b0;
  int   phase = 0;
  int   scan_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (scan_on) begin
      scan_cnt++;
      if (scan_cnt == 8) begin
        scan_cnt = 0;
        phase = (phase + 1) % 4;
      end
      col = pats[phase];
    end
  endtask

  initial begin
    logic [3:0] s_prev, s_cur;
    int pressed, ends, early_done, p1, p0, n, dcnt;
    logic seen;

    check_en = 1'b1;
    rst = 1'b1;
    tick(); tick();
    check("rst_row", {28'd0, row}, 32'hF);
    check("rst_ready", {31'd0, key_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    tick();

    // Key 5 with a rotating scanner; a foreign key offer mid-press is ignored.
    phase = 0; scan_cnt = 0; col = pats[0]; scan_on = 1'b1;
    key_valid = 1'b1; key_code = 4'h5;
    tick();
    key_valid = 1'b0;
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_ready", {31'd0, key_ready}, 32'd0);
    pressed = 0; ends = 0; early_done = 0; seen = 1'b0;
    s_cur = col;
    for (int i = 0; i < 400; i++) begin
      s_prev = s_cur;
      s_cur  = col;
      tick();
      if (i == 20) begin key_valid = 1'b1; key_code = 4'hA; end
      if (i == 21) begin key_valid = 1'b0; key_code = 4'h5; end
      if (row == 4'b1011) pressed++;
      if (s_prev == 4'b1011 && s_cur != 4'b1011) ends++;
      if (ends == 6) begin
        check("t1_done_at_6th", {31'd0, done}, 32'd1);
        seen = 1'b1;
        break;
      end
      if (done) early_done++;
    end
    check("t1_finished", {31'd0, seen}, 32'd1);
    check("t1_press_cycles", pressed, 32);
    check("t1_early_done", early_done, 0);

    // Back-to-back: key 1 then key 0 with key_valid held high.
    key_valid = 1'b1; key_code = 4'h1;
    tick();
    check("bb_busy1", {31'd0, busy}, 32'd1);
    key_code = 4'h0;
    p1 = 0; seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (row == 4'b0111) p1++;
      if (done) begin seen = 1'b1; break; end
    end
    check("bb_done1", {31'd0, seen}, 32'd1);
    check("bb_key1_rows", {31'd0, (p1 >= 24 && p1 <= 32)}, 32'd1);
    tick();
    check("bb_accept2", {31'd0, busy}, 32'd1);
    key_valid = 1'b0;
    p0 = 0; seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (row == 4'b1110) p0++;
      if (done) begin seen = 1'b1; break; end
    end
    check("bb_done2", {31'd0, seen}, 32'd1);
    check("bb_key0_rows", {31'd0, (p0 >= 24 && p0 <= 32)}, 32'd1);

    // Key D with its column never selected alone: no press, stays busy.
    scan_on = 1'b0;
    col = 4'b1011; key_valid = 1'b1; key_code = 4'hD;
    tick();
    key_valid = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (done) dcnt++; end
    col = 4'b0011;
    for (int i = 0; i < 30; i++) begin tick(); if (done) dcnt++; end
    check("d_row_idle", {28'd0, row}, 32'hF);
    check("d_busy", {31'd0, busy}, 32'd1);
    check("d_no_done", dcnt, 0);

    // Reset while key D is pressed.
    col = 4'b1110;
    tick(); tick();
    check("d_pressed", {28'd0, row}, 32'hE);
    rst = 1'b1;
    tick();
    check("rst_mid_row", {28'd0, row}, 32'hF);
    check("rst_mid_ready", {31'd0, key_ready}, 32'd1);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    col = 4'hF;
    tick();

    // No scanning after a transfer: watchdog abort or indefinite wait.
    key_valid = 1'b1; key_code = 4'h7;
    tick();
    key_valid = 1'b0;
`ifdef KEYPAD_RESP_TIMEOUT_EN
    n = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (done) begin seen = 1'b1; break; end
    end
    check("wd_seen", {31'd0, seen}, 32'd1);
    check("wd_cycle", n, TO);
    check("wd_error", {31'd0, error}, 32'd1);
    tick();
    check("wd_idle", {31'd0, key_ready}, 32'd1);
`else
    dcnt = 0;
    for (int i = 0; i < 150; i++) begin tick(); if (done) dcnt++; end
    check("wait_busy", {31'd0, busy}, 32'd1);
    check("wait_no_done", dcnt, 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_responder.md
# keypad_responder

Synthesizable 4x4 keypad emulator: the row-driving end of the column-scanned keypad interface. It accepts a key code over a valid/ready handshake, watches the active-low column strobes from a keypad scanner/decoder, and pulls the matching row line low while that key's column is selected. The key is held for a set number of column visits, then released for a set number. Used for on-board self-test of the keypad decoder path and as the keypad source in system benches.

## Interface
- HOLD_SCANS, 4, number of target-column visits during which the key reads as pressed (≥1)
- RELEASE_SCANS, 2, number of target-column visits with the key released before completion (≥1)
- TIMEOUT_CYCLES, 50000000, watchdog limit in clk cycles without a target-column visit (used only with the macro)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- col  in  4  active-low column strobes from the scanner, synchronous to clk
- row  out  4  active-low row response, registered
- key_valid  in  1  key_code is offered
- key_code  in  4  hex key to press
- key_ready  out  1  high when IDLE; transfer on key_valid && key_ready
- busy  out  1  high in PRESS or RELEASE
- done  out  1  one-cycle pulse when a key sequence completes or aborts
- error  out  1  one-cycle pulse with done on watchdog abort; constant 0 without the macro

## Operation
- Key map (col bit / row bit, low = active): col[3]: 1→row[3], 4→row[2], 7→row[1], 0→row[0]; col[2]: 2,5,8,F; col[1]: 3,6,9,E; col[0]: A,B,C,D (same row order).
- tgt_sel = col equals the one-hot-low pattern of the latched key's column (exactly one bit low). All other col values, including 4'hF and multi-low, are non-selected.
- Visit = tgt_sel going 1→0, i.e. the end of a selection window, detected against a registered copy of tgt_sel.
- States:
  - IDLE: key_ready=1, row=4'hF. On a transfer, latch the code, clear the visit counter, and go to PRESS.
  - PRESS: row = ~(one-hot row bit) in the cycle after tgt_sel=1, otherwise 4'hF. On the HOLD_SCANS-th visit, clear the counter and go to RELEASE.
  - RELEASE: row=4'hF. On the RELEASE_SCANS-th visit, go to IDLE with done=1.
- The visit counter is $clog2(max(HOLD_SCANS,RELEASE_SCANS)+1) bits wide and saturates; it never wraps.
- key_valid while busy is ignored; no queueing.

## Timing
- Reset values: row=4'hF, key_ready=1, busy=0, done=0, error=0, state IDLE, counters 0.
- Reset mid-operation aborts the sequence with no done pulse. row is 4'hF on the cycle after rst is sampled.
- Row latency is 1 cycle. Row follows tgt_sel with a one-cycle lag and releases 1 cycle after the column deselects.
- Transfer in cycle N: busy=1, key_ready=0 from cycle N+1.
- done is asserted in the first IDLE cycle, with key_ready=1 in that same cycle. A transfer in that cycle is accepted, so back-to-back keys are legal.
- Visit counting uses the registered tgt_sel, so a visit is recognised 1 cycle after the column deselects.

## Configuration
- KEYPAD_RESP_TIMEOUT_EN defined:
  - A cycle counter runs in PRESS and RELEASE and clears on every visit.
  - When it reaches TIMEOUT_CYCLES, the block goes to IDLE with done=1 and error=1 for one cycle, and row returns to 4'hF.
- KEYPAD_RESP_TIMEOUT_EN undefined: no watchdog logic, error tied 0, and the block waits indefinitely.

## Structure
- keypad_pkg holds:
  - state enum {IDLE, PRESS, RELEASE}
  - KEY_COL[16] and KEY_ROW[16] one-hot constant tables for the key map
  - the col pattern constants (4'b0111, 4'b1011, 4'b1101, 4'b1110)
- One sub-module: keypad_visit_counter (edge detect on tgt_sel plus a saturating count with terminal-count flag), instantiated once and cleared on state change.

## Test plan
- key_code=5, HOLD=4, RELEASE=2, scanner cycling 0111→1011→1101→1110 at 8 cycles each:
  - row=4'b1011 one cycle after each 1011 window starts, 4'hF otherwise.
  - Pressed for 4 windows, then released.
  - done pulses 1 cycle after the end of the 6th 1011 window.
- key_code=D with col held at 1011 or 0011 → row stays 4'hF, no visit counted, busy stays 1.
- rst asserted mid-PRESS while row=4'b1110 → row=4'hF, key_ready=1, no done pulse.
- key 1 then key 0 offered back-to-back with key_valid held high → second transfer accepted in the done cycle; row[3] then row[0] asserted during col=0111 windows.
- With KEYPAD_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=100, col=4'hF after a transfer → done=1 and error=1 at cycle 100, IDLE; without the macro, busy stays 1.
- key_valid pulsed during PRESS with a different code → ignored; the latched key is unchanged.
